// File: rtl/prism_sit_load_seq.sv
// prism_sit_load_seq: packs a 32-bit word stream into SIT entries (low word
// to 0x10, high word to 0x14) and arbitrates the SIT debug bus against the
// host debug port. Host writes are dropped while a load owns the bus.
module prism_sit_load_seq #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          s_valid,
  input  logic [31:0]   s_data,
  output logic          s_ready,
  input  logic          cfg_busy,
  input  logic [5:0]    h_addr,
  input  logic          h_wr,
  input  logic [31:0]   h_wdata,
  output logic          h_stall,
  output logic [5:0]    debug_addr,
  output logic          debug_wr,
  output logic [31:0]   debug_wdata,
  output logic          active,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] entry_cnt
);

  // Only WIDTH-32 bits of the high word are meaningful; the rest are zeroed.
  localparam int          HI_BITS = (WIDTH - 32 >= 32) ? 32 : WIDTH - 32;
  localparam logic [31:0] HI_MASK = (HI_BITS >= 32) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << HI_BITS) - 32'd1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH);
  localparam logic [5:0]    ADDR_LO  = 6'h10;
  localparam logic [5:0]    ADDR_HI  = 6'h14;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_LO    = 3'd1,
    GET_HI    = 3'd2,
    SETTLE    = 3'd3,
    WAIT_BUSY = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t        r_state;
  logic          r_seq_wr;
  logic [5:0]    r_addr;
  logic [31:0]   r_wdata;
  logic          r_settle;
  logic          r_done;
  logic          r_error;
  logic [CW-1:0] r_entry_cnt;

  logic          w_active;
  logic          w_accept;
  logic [CW-1:0] w_cnt_nxt;

  assign w_active  = (r_state == GET_LO) || (r_state == GET_HI) ||
                     (r_state == SETTLE) || (r_state == WAIT_BUSY);
  // The high word waits out the cycle in which the low-word write is on the bus.
  assign s_ready   = ((r_state == GET_LO) && !cfg_busy) ||
                     ((r_state == GET_HI) && !cfg_busy && !r_seq_wr);
  assign w_accept  = s_valid && s_ready;
  assign w_cnt_nxt = r_entry_cnt + CW'(1);

  // Load sequencer: state, write issue registers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_seq_wr    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_settle    <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_entry_cnt <= '0;
    end else begin
      r_seq_wr <= 1'b0;
      if (w_active && abort) begin
        // Cancel: any accept this cycle is discarded, count is kept for software.
        r_state <= IDLE;
        r_error <= 1'b1;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (start) begin
              r_state     <= GET_LO;
              r_entry_cnt <= '0;
              r_done      <= 1'b0;
              r_error     <= 1'b0;
            end
          end
          GET_LO: begin
            if (w_accept) begin
              r_seq_wr <= 1'b1;
              r_addr   <= ADDR_LO;
              r_wdata  <= s_data;
              r_state  <= GET_HI;
            end
          end
          GET_HI: begin
            if (w_accept) begin
              r_seq_wr <= 1'b1;
              r_addr   <= ADDR_HI;
              r_wdata  <= s_data & HI_MASK;
              r_settle <= 1'b0;
              r_state  <= SETTLE;
            end
          end
          SETTLE: begin
            // Two blind cycles give the loader time to raise its busy flag.
            if (r_settle) r_state <= WAIT_BUSY;
            else          r_settle <= 1'b1;
          end
          WAIT_BUSY: begin
            if (!cfg_busy) begin
              r_entry_cnt <= w_cnt_nxt;
              if (w_cnt_nxt == LAST_CNT) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= GET_LO;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Bus ownership follows the load; the host sees the SIT only when idle.
  assign debug_addr  = w_active ? r_addr   : h_addr;
  assign debug_wr    = w_active ? r_seq_wr : h_wr;
  assign debug_wdata = w_active ? r_wdata  : h_wdata;
  assign h_stall     = w_active && h_wr;

  assign active    = w_active;
  assign done      = r_done;
  assign error     = r_error;
  assign entry_cnt = r_entry_cnt;

endmodule

// File: tb/tb_prism_sit_load_seq.sv
// Scoreboard bench for prism_sit_load_seq: stimulus pushes expected SIT bus
// writes into a queue, a monitor pops and compares each observed debug_wr.
module tb_prism_sit_load_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        cfg_busy;
  logic        busy_auto;
  logic        busy_force;
  logic [5:0]  h_addr;
  logic        h_wr;
  logic [31:0] h_wdata;
  logic        h_stall;
  logic [5:0]  debug_addr;
  logic        debug_wr;
  logic [31:0] debug_wdata;
  logic        active;
  logic        done;
  logic        error;
  logic [2:0]  entry_cnt;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks;
  int  errors;

  assign cfg_busy = busy_auto | busy_force;

  prism_sit_load_seq #(.WIDTH(80), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .cfg_busy(cfg_busy), .h_addr(h_addr), .h_wr(h_wr), .h_wdata(h_wdata),
    .h_stall(h_stall), .debug_addr(debug_addr), .debug_wr(debug_wr),
    .debug_wdata(debug_wdata), .active(active), .done(done), .error(error),
    .entry_cnt(entry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every write seen on the SIT bus must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (debug_wr) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write",
                   debug_addr, debug_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (debug_addr !== e.a || debug_wdata !== e.d) begin
            errors++;
            $display("FAIL bus_write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                     debug_addr, debug_wdata, e.a, e.d);
          end
        end
      end
    end
  end

  // Loader model: busy for 3 cycles starting the cycle after each 0x14 write.
  initial begin
    busy_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (debug_wr && debug_addr == 6'h14) begin
        @(posedge clk);
        #1 busy_auto = 1'b1;
        repeat (3) @(posedge clk);
        #1 busy_auto = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // All driving tasks are entered and left 1 time unit after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: word %0h got no s_ready, required accept", d);
    end
  endtask

  task automatic push_send(input logic [5:0] a, input logic [31:0] d);
    exp_q.push_back(wr_t'({a, d}));
    send_word(d);
  endtask

  task automatic host_write(input logic [5:0] a, input logic [31:0] d, input bit fwd);
    if (fwd) exp_q.push_back(wr_t'({a, d}));
    h_addr  = a;
    h_wdata = d;
    h_wr    = 1'b1;
    #1;
    chk("h_stall", h_stall, {31'd0, !fwd});
    @(posedge clk); #1;
    h_wr = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_reached", done, 1);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    s_valid = 1'b0; s_data = '0; busy_force = 1'b0;
    h_addr = '0; h_wr = 1'b0; h_wdata = '0;

    // Reset state
    #2;
    chk("rst_active", active, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_entry_cnt", entry_cnt, 0);
    chk("rst_debug_wr", debug_wr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Asynchronous reset in the middle of GET_HI
    @(posedge clk); #1;
    pulse_start();
    push_send(6'h10, 32'hAAAA_0001);
    @(posedge clk); #1;
    chk("mid_load_active", active, 1);
    exp_q.push_back(wr_t'({6'h05, 32'h1234_5678}));
    h_addr = 6'h05; h_wdata = 32'h1234_5678; h_wr = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_active", active, 0);
    chk("arst_debug_wr", debug_wr, 1);
    chk("arst_debug_addr", debug_addr, 6'h05);
    chk("arst_h_stall", h_stall, 0);
    chk("arst_entry_cnt", entry_cnt, 0);
    chk("arst_error", error, 0);
    @(posedge clk); #1;
    h_wr = 1'b0;
    #1;
    chk("arst_debug_wr_low", debug_wr, 0);
    rst_n = 1'b1;

    // Full load of four entries with the loader busy after each high write
    @(posedge clk); #1;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      push_send(6'h10, 32'h1000_0000 + 32'(2 * k));
      chk("load_entry_cnt", entry_cnt, k);
      if (k == 1) host_write(6'h10, 32'hBAD0_0001, 1'b0);
      push_send(6'h14, 32'h1000_0001 + 32'(2 * k));
    end
    wait_done();
    chk("load_active", active, 0);
    chk("load_entry_cnt_final", entry_cnt, 4);
    chk("load_error", error, 0);
    chk("load_queue_drained", exp_q.size(), 0);

    // Host write after done is forwarded; abort while idle does nothing
    host_write(6'h10, 32'hDEAD_BEEF, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("idle_abort_done", done, 1);
    chk("idle_abort_error", error, 0);

    // Loader busy holds off the low word for 10 cycles
    busy_force = 1'b1;
    pulse_start();
    s_valid = 1'b1; s_data = 32'h2000_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_s_ready", s_ready, 0);
      @(posedge clk); #1;
    end
    busy_force = 1'b0;
    exp_q.push_back(wr_t'({6'h10, 32'h2000_0000}));
    @(negedge clk);
    chk("bp_s_ready_released", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("bp_write_wr", debug_wr, 1);
    chk("bp_write_addr", debug_addr, 6'h10);
    @(posedge clk); #1;

    // Abort after entry 2's low word
    push_send(6'h14, 32'h2000_0001);
    push_send(6'h10, 32'h2000_0002);
    push_send(6'h14, 32'h2000_0003);
    push_send(6'h10, 32'h2000_0004);
    abort = 1'b1;
    s_valid = 1'b1; s_data = 32'h2000_0005;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_active", active, 0);
    chk("abort_error", error, 1);
    chk("abort_entry_cnt", entry_cnt, 2);
    chk("abort_s_ready", s_ready, 0);
    repeat (5) @(posedge clk);
    #1 s_valid = 1'b0;
    chk("abort_queue_drained", exp_q.size(), 0);

    // start and abort together in IDLE: start wins
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("sa_active", active, 1);
    chk("sa_error", error, 0);
    chk("sa_done", done, 0);
    chk("sa_entry_cnt", entry_cnt, 0);

    // start during WAIT_BUSY is ignored
    push_send(6'h10, 32'h3000_0000);
    push_send(6'h14, 32'h3000_0001);
    repeat (2) @(posedge clk);
    #1;
    chk("wb_cfg_busy", cfg_busy, 1);
    pulse_start();
    chk("wb_active", active, 1);
    chk("wb_entry_cnt", entry_cnt, 0);
    for (int i = 0; i < 20 && entry_cnt != 3'd1; i++) begin
      @(posedge clk); #1;
    end
    chk("wb_entry_cnt_step", entry_cnt, 1);
    chk("wb_s_ready", s_ready, 1);
    for (int k = 1; k < 4; k++) begin
      push_send(6'h10, 32'h3000_0000 + 32'(2 * k));
      push_send(6'h14, 32'h3000_0001 + 32'(2 * k));
    end
    wait_done();
    chk("final_entry_cnt", entry_cnt, 4);
    chk("final_queue_drained", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
